// File: rtl/z16_mem_arbiter.sv
// z16_mem_arbiter
// Shares one single-port Z16 memory between the instruction-fetch (IF) port
// and the data (DM) port. One access is in flight at a time: a grant latches
// the request, the fixed-latency memory access is sequenced by a down-counter,
// and the read data (or a zero write ack) is returned to the winning port.
// Optional feature macro: Z16_ARB_RR_EN
//   undefined -> fixed priority, DM always wins a tie
//   defined   -> round-robin, the port not granted last wins a tie
module z16_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_dm_req,
  input  logic              i_dm_wen,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic              o_dm_gnt,
  output logic              o_dm_rvalid,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wen,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // Number of extra ACCESS cycles after the first one.
  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  if ((MEM_LAT < 1) || (MEM_LAT > 4)) begin : g_lat_check
    $error("z16_mem_arbiter: MEM_LAT=%0d is outside the legal range 1..4", MEM_LAT);
  end

  state_t              state_r,     state_s;
  logic [1:0]          cnt_r,       cnt_s;
  logic                prio_dm_r,   prio_dm_s;
  logic                owner_dm_r,  owner_dm_s;
  logic                op_wen_r,    op_wen_s;
  logic                if_gnt_r,    if_gnt_s;
  logic                dm_gnt_r,    dm_gnt_s;
  logic                if_rvalid_r, if_rvalid_s;
  logic                dm_rvalid_r, dm_rvalid_s;
  logic [DATA_W-1:0]   if_rdata_r,  if_rdata_s;
  logic [DATA_W-1:0]   dm_rdata_r,  dm_rdata_s;
  logic [ADDR_W-1:0]   mem_addr_r,  mem_addr_s;
  logic                mem_wen_r,   mem_wen_s;
  logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
  logic                busy_r,      busy_s;
  logic                pick_dm_s;

  // Next-state and next-output logic of the access sequencer.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    prio_dm_s   = prio_dm_r;
    owner_dm_s  = owner_dm_r;
    op_wen_s    = op_wen_r;
    if_gnt_s    = 1'b0;
    dm_gnt_s    = 1'b0;
    if_rvalid_s = 1'b0;
    dm_rvalid_s = 1'b0;
    if_rdata_s  = if_rdata_r;
    dm_rdata_s  = dm_rdata_r;
    mem_addr_s  = mem_addr_r;
    mem_wen_s   = 1'b0;
    mem_wdata_s = mem_wdata_r;
    busy_s      = busy_r;
    // DM wins when alone, or on a tie while it holds priority. In the
    // fixed-priority build prio_dm_r never leaves its reset value (DM).
    pick_dm_s   = i_dm_req & (~i_if_req | prio_dm_r);

    case (state_r)
      ST_IDLE: begin
        if (i_if_req | i_dm_req) begin
          state_s    = ST_ACCESS;
          cnt_s      = LAT_M1;
          busy_s     = 1'b1;
          owner_dm_s = pick_dm_s;
`ifdef Z16_ARB_RR_EN
          prio_dm_s  = ~pick_dm_s;
`endif
          if (pick_dm_s) begin
            dm_gnt_s    = 1'b1;
            mem_addr_s  = i_dm_addr;
            mem_wdata_s = i_dm_wdata;
            mem_wen_s   = i_dm_wen;
            op_wen_s    = i_dm_wen;
          end else begin
            if_gnt_s    = 1'b1;
            mem_addr_s  = i_if_addr;
            mem_wdata_s = {DATA_W{1'b0}};
            op_wen_s    = 1'b0;
          end
        end else begin
          busy_s      = 1'b0;
          mem_addr_s  = {ADDR_W{1'b0}};
          mem_wdata_s = {DATA_W{1'b0}};
        end
      end

      ST_ACCESS: begin
        // Requests are deliberately not looked at while an access is in flight.
        if (cnt_r != 2'd0) begin
          cnt_s = cnt_r - 2'd1;
        end else begin
          state_s     = ST_IDLE;
          busy_s      = 1'b0;
          mem_addr_s  = {ADDR_W{1'b0}};
          mem_wdata_s = {DATA_W{1'b0}};
          if (owner_dm_r) begin
            dm_rvalid_s = 1'b1;
            dm_rdata_s  = op_wen_r ? {DATA_W{1'b0}} : i_mem_rdata;
          end else begin
            if_rvalid_s = 1'b1;
            if_rdata_s  = i_mem_rdata;
          end
        end
      end

      default: begin
        state_s     = ST_IDLE;
        cnt_s       = 2'd0;
        busy_s      = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // State and registered-output flops; reset drops any in-flight access.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 2'd0;
      prio_dm_r   <= 1'b1;
      owner_dm_r  <= 1'b0;
      op_wen_r    <= 1'b0;
      if_gnt_r    <= 1'b0;
      dm_gnt_r    <= 1'b0;
      if_rvalid_r <= 1'b0;
      dm_rvalid_r <= 1'b0;
      if_rdata_r  <= {DATA_W{1'b0}};
      dm_rdata_r  <= {DATA_W{1'b0}};
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wen_r   <= 1'b0;
      mem_wdata_r <= {DATA_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      prio_dm_r   <= prio_dm_s;
      owner_dm_r  <= owner_dm_s;
      op_wen_r    <= op_wen_s;
      if_gnt_r    <= if_gnt_s;
      dm_gnt_r    <= dm_gnt_s;
      if_rvalid_r <= if_rvalid_s;
      dm_rvalid_r <= dm_rvalid_s;
      if_rdata_r  <= if_rdata_s;
      dm_rdata_r  <= dm_rdata_s;
      mem_addr_r  <= mem_addr_s;
      mem_wen_r   <= mem_wen_s;
      mem_wdata_r <= mem_wdata_s;
      busy_r      <= busy_s;
    end
  end

  assign o_if_gnt    = if_gnt_r;
  assign o_if_rvalid = if_rvalid_r;
  assign o_if_rdata  = if_rdata_r;
  assign o_dm_gnt    = dm_gnt_r;
  assign o_dm_rvalid = dm_rvalid_r;
  assign o_dm_rdata  = dm_rdata_r;
  assign o_mem_addr  = mem_addr_r;
  assign o_mem_wen   = mem_wen_r;
  assign o_mem_wdata = mem_wdata_r;
  assign o_busy      = busy_r;

endmodule

// File: tb/tb_z16_mem_arbiter.sv
// Testbench for z16_mem_arbiter (MEM_LAT=3). A transaction-level reference
// model tracks one outstanding access at a time and pushes expected grants,
// completions and memory writes into queues; an independent monitor pops and
// compares whenever the DUT presents one, and checks idle/hold values per cycle.
module tb_z16_mem_arbiter;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_if_req, i_dm_req, i_dm_wen;
  logic [15:0] i_if_addr, i_dm_addr, i_dm_wdata, i_mem_rdata;
  logic        o_if_gnt, o_if_rvalid, o_dm_gnt, o_dm_rvalid, o_mem_wen, o_busy;
  logic [15:0] o_if_rdata, o_dm_rdata, o_mem_addr, o_mem_wdata;

  always #5 clk = ~clk;

  z16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_dm_req(i_dm_req), .i_dm_wen(i_dm_wen), .i_dm_addr(i_dm_addr),
    .i_dm_wdata(i_dm_wdata), .o_dm_gnt(o_dm_gnt), .o_dm_rvalid(o_dm_rvalid),
    .o_dm_rdata(o_dm_rdata), .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
  );

  // ---------------- memory: word array behind a LAT-deep read pipe ----------
  logic [15:0] phys_mem [64];
  logic [15:0] ref_mem  [64];
  logic [15:0] pipe     [LAT];

  always @(posedge clk) begin
    if (o_mem_wen) phys_mem[o_mem_addr[6:1]] <= o_mem_wdata;
    pipe[0] <= phys_mem[o_mem_addr[6:1]];
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end

  if (LAT == 1) begin : g_mem_lat1
    assign i_mem_rdata = phys_mem[o_mem_addr[6:1]];
  end else begin : g_mem_latn
    assign i_mem_rdata = pipe[LAT-2];
  end

  // ---------------- check bookkeeping ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    $display("FAIL %s: got no event expected one within budget (t=%0t)", nm, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit dm; int cyc; logic [15:0] data; } ev_t;
  typedef struct { int cyc; logic [15:0] addr; logic [15:0] data; } wr_t;
  ev_t gnt_q[$];
  ev_t rv_q[$];
  wr_t wr_q[$];

  int          cyc = 0;
  int          acc_end = 0;
  bit          in_acc = 1'b0;
  bit          cur_dm = 1'b0;
  bit          win_dm = 1'b0;
  bit          rr_dm  = 1'b1;
  logic [15:0] cur_addr = 16'h0, cur_wdata = 16'h0, cur_data = 16'h0;
  logic [15:0] hold_if = 16'h0, hold_dm = 16'h0;

  // One access at a time; it completes LAT edges after its grant edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_acc = 1'b0; rr_dm = 1'b1; hold_if = 16'h0; hold_dm = 16'h0;
      gnt_q.delete(); rv_q.delete(); wr_q.delete();
    end else begin
      cyc++;
      if (in_acc) begin
        if (cyc == acc_end) begin
          in_acc = 1'b0;
          if (cur_dm) hold_dm = cur_data; else hold_if = cur_data;
        end
      end else if (i_if_req || i_dm_req) begin
        if (i_if_req && i_dm_req) begin
`ifdef Z16_ARB_RR_EN
          win_dm = rr_dm;
`else
          win_dm = 1'b1;
`endif
        end else begin
          win_dm = i_dm_req;
        end
        rr_dm    = !win_dm;
        cur_dm   = win_dm;
        cur_addr = win_dm ? i_dm_addr : i_if_addr;
        cur_wdata = win_dm ? i_dm_wdata : 16'h0;
        if (win_dm && i_dm_wen) begin
          cur_data = 16'h0;
          ref_mem[cur_addr[6:1]] = i_dm_wdata;
          wr_q.push_back('{cyc: cyc, addr: cur_addr, data: i_dm_wdata});
        end else begin
          cur_data = ref_mem[cur_addr[6:1]];
        end
        gnt_q.push_back('{dm: win_dm, cyc: cyc, data: 16'h0});
        rv_q.push_back('{dm: win_dm, cyc: cyc + LAT, data: cur_data});
        in_acc  = 1'b1;
        acc_end = cyc + LAT;
      end
    end
  end

  // ---------------- monitor ----------------
  ev_t e;
  wr_t w;
  // Pops an expectation whenever the DUT shows an event or one is overdue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_if_gnt || o_dm_gnt || (gnt_q.size() > 0 && gnt_q[0].cyc <= cyc)) begin
        if (gnt_q.size() == 0) chk("gnt_unexpected", {62'd0, o_if_gnt, o_dm_gnt}, 64'd0);
        else begin
          e = gnt_q.pop_front();
          chk("gnt_port", {62'd0, o_if_gnt, o_dm_gnt}, e.dm ? 64'd1 : 64'd2);
          chk("gnt_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (o_if_rvalid || o_dm_rvalid || (rv_q.size() > 0 && rv_q[0].cyc <= cyc)) begin
        if (rv_q.size() == 0) chk("rvalid_unexpected", {62'd0, o_if_rvalid, o_dm_rvalid}, 64'd0);
        else begin
          e = rv_q.pop_front();
          chk("rvalid_port", {62'd0, o_if_rvalid, o_dm_rvalid}, e.dm ? 64'd1 : 64'd2);
          chk("rvalid_cycle", 64'(cyc), 64'(e.cyc));
          chk("rdata", {48'd0, (e.dm ? o_dm_rdata : o_if_rdata)}, {48'd0, e.data});
        end
      end
      if (o_mem_wen || (wr_q.size() > 0 && wr_q[0].cyc <= cyc)) begin
        if (wr_q.size() == 0) chk("wen_unexpected", {63'd0, o_mem_wen}, 64'd0);
        else begin
          w = wr_q.pop_front();
          chk("wen_pulse", {63'd0, o_mem_wen}, 64'd1);
          chk("wen_cycle", 64'(cyc), 64'(w.cyc));
          chk("wen_addr_data", {32'd0, o_mem_addr, o_mem_wdata}, {32'd0, w.addr, w.data});
        end
      end
      chk("busy_mem_bus", {31'd0, o_busy, o_mem_addr, o_mem_wdata},
          {31'd0, in_acc, (in_acc ? cur_addr : 16'h0), (in_acc ? cur_wdata : 16'h0)});
      chk("rdata_hold", {32'd0, o_if_rdata, o_dm_rdata}, {32'd0, hold_if, hold_dm});
    end
  end

  // ---------------- requester ----------------
  // Called #1 after a rising edge; holds req until gnt, then waits for rvalid.
  task automatic issue(input bit dm, input bit wen, input logic [15:0] addr, input logic [15:0] wdata);
    int t;
    if (dm) begin
      i_dm_req = 1'b1; i_dm_wen = wen; i_dm_addr = addr; i_dm_wdata = wdata;
    end else begin
      i_if_req = 1'b1; i_if_addr = addr;
    end
    t = 0;
    do begin @(posedge clk); #1; t++; end
    while (!(dm ? o_dm_gnt : o_if_gnt) && t < 300);
    if (dm) i_dm_req = 1'b0; else i_if_req = 1'b0;
    if (t >= 300) begin tmo(dm ? "dm_gnt_wait" : "if_gnt_wait"); return; end
    t = 0;
    do begin @(posedge clk); #1; t++; end
    while (!(dm ? o_dm_rvalid : o_if_rvalid) && t < 300);
    if (t >= 300) tmo(dm ? "dm_rvalid_wait" : "if_rvalid_wait");
  endtask

  task automatic rand_port(input bit dm, input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
      issue(dm, dm ? 1'($urandom_range(0, 1)) : 1'b0,
            {9'd0, 6'($urandom_range(0, 63)), 1'b0}, 16'($urandom));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    logic [15:0] v;
    rst_n = 1'b0;
    i_if_req = 1'b0; i_dm_req = 1'b0; i_dm_wen = 1'b0;
    i_if_addr = 16'h0; i_dm_addr = 16'h0; i_dm_wdata = 16'h0;
    for (int i = 0; i < 64; i++) begin
      v = 16'($urandom);
      phys_mem[i] <= v;
      ref_mem[i] = v;
    end
    phys_mem[1] <= 16'hA5C3;
    ref_mem[1] = 16'hA5C3;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {58'd0, o_if_gnt, o_dm_gnt, o_if_rvalid, o_dm_rvalid, o_busy, o_mem_wen}, 64'd0);
    chk("reset_data", {o_mem_addr, o_mem_wdata, o_if_rdata, o_dm_rdata}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // IF read of 0x0002 returning 0xA5C3, then DM write 0x1234 to 0x0100.
    issue(1'b0, 1'b0, 16'h0002, 16'h0000);
    issue(1'b1, 1'b1, 16'h0100, 16'h1234);
    issue(1'b1, 1'b0, 16'h0100, 16'h5555);

    // Reset in the middle of a DM read: outputs drop at once, no completion follows.
    i_dm_req = 1'b1; i_dm_wen = 1'b0; i_dm_addr = 16'h0010;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!o_dm_gnt && t < 20);
    i_dm_req = 1'b0;
    if (t >= 20) tmo("mid_reset_gnt_wait");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_ctrl", {58'd0, o_if_gnt, o_dm_gnt, o_if_rvalid, o_dm_rvalid, o_busy, o_mem_wen}, 64'd0);
    chk("mid_reset_data", {o_mem_addr, o_mem_wdata, o_if_rdata, o_dm_rdata}, 64'd0);
    @(negedge clk); #1; rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end

    // Simultaneous IF + DM requests, twice in a row.
    fork
      begin issue(1'b1, 1'b0, 16'h0004, 16'h0000); issue(1'b1, 1'b1, 16'h0006, 16'hBEEF); end
      begin issue(1'b0, 1'b0, 16'h0008, 16'h0000); issue(1'b0, 1'b0, 16'h0006, 16'h0000); end
    join

    // Back-to-back IF reads.
    issue(1'b0, 1'b0, 16'h0000, 16'h0000);
    issue(1'b0, 1'b0, 16'h0002, 16'h0000);

    // Randomised contention on both ports.
    fork
      rand_port(1'b1, 40);
      rand_port(1'b0, 40);
    join

    repeat (LAT + 4) begin @(posedge clk); #1; end
    chk("queues_drained", 64'(gnt_q.size() + rv_q.size() + wr_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
